mfp_reset_sequencer: RTL and testbench
======================================

Name: mfp_reset_sequencer

Overview:
- Board-level reset controller that sequences reset for the MIPSfpga system core (mfp_sys) and arbitrates ownership of the core between normal execution and the UART program loader.
- Merges four reset sources: master reset, debounced centre pushbutton, EJTAG cold-reset request, and loader hold-request.
- Drives the core's warm and cold reset inputs with a guaranteed minimum hold time.
- Sits between the board pins/clock wizard and mfp_sys in the board top level.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a synchronised button level must be stable before it is accepted (10 ms at 50 MHz).
- HOLD_CYCLES, 16, minimum number of cycles the core resets stay asserted after the last reset cause clears; must be ≥ 2.

Ports:
- SI_ClkIn  input  1  system clock (clock wizard output).
- SI_Reset_N  input  1  master reset, asynchronous, active-low.
- btn_rst  input  1  raw centre pushbutton, active-high, asynchronous to SI_ClkIn.
- ej_cold_n  input  1  EJTAG cold-reset request, active-low, asynchronous.
- ldr_req  input  1  loader request to hold the core, synchronous, level.
- ldr_done  input  1  loader finished, synchronous, single-cycle pulse.
- core_reset_n  output  1  warm reset to mfp_sys (SI_Reset_N of core), active-low.
- core_cold_reset_n  output  1  cold reset to mfp_sys, active-low.
- ldr_grant  output  1  loader owns memory; core held in reset.
- rst_cause  output  2  last reset cause, sticky: 0 power-on, 1 button, 2 EJTAG, 3 loader.

Behaviour:
- Clock and reset: one clock, SI_ClkIn. SI_Reset_N is asynchronous and active-low.
- Reset values (SI_Reset_N low):
  - state = HOLD, cold flag = 1, hold counter = 0.
  - core_reset_n = 0, core_cold_reset_n = 0, ldr_grant = 0, rst_cause = 0.
  - Synchronisers and the debounce stable level reset to inactive (button 0, EJTAG 1); debounce counter = 0.
  - Asserting SI_Reset_N mid-operation, including in LOAD, forces these values immediately.
- Synchronisation:
  - btn_rst and ej_cold_n each pass through a 2-flop synchroniser.
  - ldr_req and ldr_done are used directly.
- Debounce:
  - The counter clears whenever the synchronised button equals the stable level; otherwise it increments.
  - At DEBOUNCE_CYCLES-1 the stable level toggles and the counter clears.
  - btn_evt is a one-cycle pulse on each stable 0→1 transition.
  - Glitches shorter than DEBOUNCE_CYCLES never produce btn_evt.
- FSM states: HOLD, RUN, LOAD. All outputs are registered and decoded from next-state.
- HOLD:
  - core_reset_n = 0; core_cold_reset_n = ~cold flag; ldr_grant = 0.
  - Synced ej_cold_n low: counter = 0, cold flag = 1, rst_cause = 2.
  - btn_evt: counter = 0, rst_cause = 1.
  - Otherwise the counter increments. At HOLD_CYCLES-1 the FSM goes to RUN and the cold flag clears.
- RUN:
  - core_reset_n = 1, core_cold_reset_n = 1, ldr_grant = 0.
  - Transitions in priority order:
    1. Synced ej_cold_n low → HOLD, cold flag = 1, rst_cause = 2.
    2. btn_evt → HOLD, cold flag = 0, rst_cause = 1.
    3. ldr_req → LOAD, rst_cause = 3.
  - Counter cleared on every exit.
- LOAD:
  - core_reset_n = 0, core_cold_reset_n = 1, ldr_grant = 1.
  - Transitions in priority order:
    1. EJTAG cold request → HOLD, cold flag = 1, cause 2.
    2. btn_evt → HOLD, warm, cause 1.
    3. ldr_done, or ldr_req low → HOLD, warm, cause unchanged.
  - ldr_grant deasserts in the same cycle core_reset_n would have been released, so the grant never overlaps a running core.
- Simultaneous events are resolved by the fixed priority EJTAG > button > loader.
- Latency:
  - ej_cold_n falling → core_cold_reset_n low at the 3rd SI_ClkIn edge.
  - ldr_req high in RUN → ldr_grant and core_reset_n low at the next edge.
  - Exit from HOLD occurs exactly HOLD_CYCLES cycles after the last restart condition.
- The power-on sequence is a cold reset: after SI_Reset_N deasserts, both resets stay low for HOLD_CYCLES cycles.

Test Plan:
- Power-on: release SI_Reset_N, HOLD_CYCLES=16 → both resets rise together exactly 16 cycles later; rst_cause = 0; ldr_grant = 0 throughout.
- Button debounce (DEBOUNCE_CYCLES=8): 5-cycle btn_rst glitch → no reset. 20-cycle press in RUN → core_reset_n low for 16 cycles, core_cold_reset_n stays 1, rst_cause = 1.
- EJTAG cold: drive ej_cold_n low for 40 cycles in RUN → core_cold_reset_n low 3 edges later and held until 16 cycles after the synced release; rst_cause = 2.
- Loader: ldr_req high in RUN, ldr_done pulse 100 cycles later → ldr_grant = 1 and core_reset_n = 0 for the whole window; then 16-cycle HOLD and RUN; rst_cause = 3.
- Priority and abort: btn_evt and ej_cold_n low in the same cycle during LOAD → ldr_grant drops next cycle, cold flag set, rst_cause = 2.
- Async reset mid-LOAD: pulse SI_Reset_N low → all outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mfp_reset_sequencer.sv
// rtl/mfp_reset_sequencer.sv - reset sources merge, debounce and core reset/loader ownership sequencer
module mfp_reset_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 16
) (
    input  logic       SI_ClkIn,
    input  logic       SI_Reset_N,
    input  logic       btn_rst,
    input  logic       ej_cold_n,
    input  logic       ldr_req,
    input  logic       ldr_done,
    output logic       core_reset_n,
    output logic       core_cold_reset_n,
    output logic       ldr_grant,
    output logic [1:0] rst_cause
);

    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_BTN  = 2'd1;
    localparam logic [1:0] CAUSE_EJTAG = 2'd2;
    localparam logic [1:0] CAUSE_LDR  = 2'd3;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    // Synchroniser stages; reset to the inactive level of each source
    logic btn_s1, btn_s2;
    logic ej_s1, ej_s2;

    // Debounce state
    logic [DB_W-1:0] db_cnt;
    logic            db_stable;
    logic            btn_evt;

    // Sequencer state
    state_t            state_q, state_d;
    logic              cold_q, cold_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]        cause_q, cause_d;

    // Next values of the registered outputs
    logic core_reset_n_d;
    logic core_cold_reset_n_d;
    logic ldr_grant_d;

    // Two-flop synchronisers for the asynchronous button and EJTAG request
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            ej_s1  <= 1'b1;
            ej_s2  <= 1'b1;
        end else begin
            btn_s1 <= btn_rst;
            btn_s2 <= btn_s1;
            ej_s1  <= ej_cold_n;
            ej_s2  <= ej_s1;
        end
    end

    // Button debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples;
    // btn_evt pulses for one cycle when the accepted level rises
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            db_cnt    <= '0;
            db_stable <= 1'b0;
            btn_evt   <= 1'b0;
        end else begin
            btn_evt <= 1'b0;
            if (btn_s2 == db_stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt    <= '0;
                db_stable <= ~db_stable;
                btn_evt   <= ~db_stable;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Sequencer next-state: EJTAG beats button beats loader in every state
    always_comb begin
        state_d    = state_q;
        cold_d     = cold_q;
        hold_cnt_d = hold_cnt_q;
        cause_d    = cause_q;

        case (state_q)
            ST_HOLD: begin
                if (!ej_s2) begin
                    hold_cnt_d = '0;
                    cold_d     = 1'b1;
                    cause_d    = CAUSE_EJTAG;
                end else if (btn_evt) begin
                    hold_cnt_d = '0;
                    cause_d    = CAUSE_BTN;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    state_d    = ST_RUN;
                    cold_d     = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            ST_RUN: begin
                hold_cnt_d = '0;
                if (!ej_s2) begin
                    state_d = ST_HOLD;
                    cold_d  = 1'b1;
                    cause_d = CAUSE_EJTAG;
                end else if (btn_evt) begin
                    state_d = ST_HOLD;
                    cold_d  = 1'b0;
                    cause_d = CAUSE_BTN;
                end else if (ldr_req) begin
                    state_d = ST_LOAD;
                    cause_d = CAUSE_LDR;
                end
            end

            ST_LOAD: begin
                hold_cnt_d = '0;
                if (!ej_s2) begin
                    state_d = ST_HOLD;
                    cold_d  = 1'b1;
                    cause_d = CAUSE_EJTAG;
                end else if (btn_evt) begin
                    state_d = ST_HOLD;
                    cold_d  = 1'b0;
                    cause_d = CAUSE_BTN;
                end else if (ldr_done || !ldr_req) begin
                    // Loader hands back through a warm hold so the grant drops before the core runs
                    state_d = ST_HOLD;
                    cold_d  = 1'b0;
                end
            end

            default: begin
                state_d    = ST_HOLD;
                cold_d     = 1'b1;
                hold_cnt_d = '0;
            end
        endcase

        // Outputs decoded from the next state so they change on the same edge as the state
        core_reset_n_d      = (state_d == ST_RUN);
        core_cold_reset_n_d = (state_d == ST_HOLD) ? ~cold_d : 1'b1;
        ldr_grant_d         = (state_d == ST_LOAD);
    end

    // Sequencer state and registered outputs; power-on starts as a cold hold
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            state_q           <= ST_HOLD;
            cold_q            <= 1'b1;
            hold_cnt_q        <= '0;
            cause_q           <= CAUSE_POR;
            core_reset_n      <= 1'b0;
            core_cold_reset_n <= 1'b0;
            ldr_grant         <= 1'b0;
        end else begin
            state_q           <= state_d;
            cold_q            <= cold_d;
            hold_cnt_q        <= hold_cnt_d;
            cause_q           <= cause_d;
            core_reset_n      <= core_reset_n_d;
            core_cold_reset_n <= core_cold_reset_n_d;
            ldr_grant         <= ldr_grant_d;
        end
    end

    assign rst_cause = cause_q;

endmodule

// File: tb/tb_mfp_reset_sequencer.sv
// tb/tb_mfp_reset_sequencer.sv - self-checking bench for mfp_reset_sequencer
module tb_mfp_reset_sequencer;

    localparam int D = 8;
    localparam int H = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_rst;
    logic       ej_cold_n;
    logic       ldr_req;
    logic       ldr_done;
    logic       core_reset_n;
    logic       core_cold_reset_n;
    logic       ldr_grant;
    logic [1:0] rst_cause;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    mfp_reset_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H)
    ) dut (
        .SI_ClkIn         (clk),
        .SI_Reset_N       (rst_n),
        .btn_rst          (btn_rst),
        .ej_cold_n        (ej_cold_n),
        .ldr_req          (ldr_req),
        .ldr_done         (ldr_done),
        .core_reset_n     (core_reset_n),
        .core_cold_reset_n(core_cold_reset_n),
        .ldr_grant        (ldr_grant),
        .rst_cause        (rst_cause)
    );

    always #5 clk = ~clk;

    // Reference model: edge-indexed sample histories and an absolute release edge
    typedef enum int {M_HOLD, M_RUN, M_LOAD} mode_t;
    mode_t    m_mode;
    bit       m_cold;
    bit [1:0] m_cause;
    int       m_k;
    int       m_release_at;
    bit       m_stable;
    bit       m_evt;
    int       m_base;
    bit       q_ej[$];
    bit       q_btn[$];
    bit       q_sb[$];

    function automatic void model_reset();
        m_mode = M_HOLD;
        m_cold = 1'b1;
        m_cause = 2'd0;
        m_k = 0;
        m_release_at = H;
        m_stable = 1'b0;
        m_evt = 1'b0;
        m_base = 0;
        q_ej = '{1'b1, 1'b1};
        q_btn = '{1'b0, 1'b0};
        q_sb.delete();
    endfunction

    function automatic void go_hold(input bit cold, input bit [1:0] cause);
        m_mode = M_HOLD;
        m_cold = cold;
        m_cause = cause;
        m_release_at = m_k + H;
    endfunction

    function automatic void model_step();
        bit ej_s;
        bit btn_s;
        bit all_diff;
        m_k++;
        q_ej.push_back(ej_cold_n);
        q_btn.push_back(btn_rst);
        ej_s  = q_ej[q_ej.size() - 3];
        btn_s = q_btn[q_btn.size() - 3];
        case (m_mode)
            M_HOLD: begin
                if (!ej_s) begin
                    m_cold = 1'b1; m_cause = 2'd2; m_release_at = m_k + H;
                end else if (m_evt) begin
                    m_cause = 2'd1; m_release_at = m_k + H;
                end else if (m_k == m_release_at) begin
                    m_mode = M_RUN; m_cold = 1'b0;
                end
            end
            M_RUN: begin
                if (!ej_s) go_hold(1'b1, 2'd2);
                else if (m_evt) go_hold(1'b0, 2'd1);
                else if (ldr_req) begin
                    m_mode = M_LOAD; m_cause = 2'd3;
                end
            end
            default: begin
                if (!ej_s) go_hold(1'b1, 2'd2);
                else if (m_evt) go_hold(1'b0, 2'd1);
                else if (ldr_done || !ldr_req) go_hold(1'b0, m_cause);
            end
        endcase
        q_sb.push_back(btn_s);
        m_evt = 1'b0;
        if (q_sb.size() - m_base >= D) begin
            all_diff = 1'b1;
            for (int i = 0; i < D; i++)
                if (q_sb[q_sb.size() - 1 - i] == m_stable) all_diff = 1'b0;
            if (all_diff) begin
                m_stable = ~m_stable;
                m_base = q_sb.size();
                m_evt = m_stable;
            end
        end
    endfunction

    function automatic logic [4:0] model_exp();
        return {m_mode == M_RUN, (m_mode != M_HOLD) || !m_cold, m_mode == M_LOAD, m_cause};
    endfunction

    function automatic logic [4:0] outs();
        return {core_reset_n, core_cold_reset_n, ldr_grant, rst_cause};
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s edge%0d: observed {rst,cold,grant,cause}=%b required %b", tag, m_k, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (rst_n) model_step();
            #1;
            check("cycle", outs(), model_exp());
        end
    endtask

    int btn_left;
    int ej_left;

    initial begin
        rst_n = 1'b0;
        btn_rst = 1'b0;
        ej_cold_n = 1'b1;
        ldr_req = 1'b0;
        ldr_done = 1'b0;
        model_reset();
        cyc(3);
        check("por_in_reset", outs(), 5'b00000);
        #2 rst_n = 1'b1;

        // Power-on cold hold
        cyc(15);
        check("por_hold15", outs(), 5'b00000);
        cyc(1);
        check("por_release", outs(), 5'b11000);

        // Short button glitch is filtered
        btn_rst = 1'b1;
        cyc(5);
        btn_rst = 1'b0;
        cyc(30);
        check("glitch_ignored", outs(), 5'b11000);

        // Debounced press gives a warm reset
        btn_rst = 1'b1;
        cyc(12);
        check("btn_warm_hold", outs(), 5'b01001);
        cyc(8);
        btn_rst = 1'b0;
        cyc(30);
        check("btn_run", outs(), 5'b11001);

        // EJTAG cold reset, visible at the 3rd edge
        ej_cold_n = 1'b0;
        cyc(3);
        check("ej_cold_3rd_edge", outs(), 5'b00010);
        cyc(37);
        ej_cold_n = 1'b1;
        cyc(40);
        check("ej_run", outs(), 5'b11010);

        // Loader window
        ldr_req = 1'b1;
        cyc(1);
        check("ldr_grant_next_edge", outs(), 5'b01111);
        cyc(99);
        check("ldr_window", outs(), 5'b01111);
        ldr_done = 1'b1;
        cyc(1);
        check("ldr_done_hold", outs(), 5'b01011);
        ldr_done = 1'b0;
        ldr_req = 1'b0;
        cyc(20);
        check("ldr_run", outs(), 5'b11011);

        // Button event and EJTAG request land on the same edge during LOAD
        ldr_req = 1'b1;
        cyc(5);
        btn_rst = 1'b1;
        cyc(8);
        ej_cold_n = 1'b0;
        cyc(3);
        check("prio_ej_over_btn", outs(), 5'b00010);
        ej_cold_n = 1'b1;
        btn_rst = 1'b0;
        ldr_req = 1'b0;
        cyc(40);
        check("prio_run", outs(), 5'b11010);

        // Asynchronous reset in the middle of LOAD
        ldr_req = 1'b1;
        cyc(10);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_load", outs(), 5'b00000);
        ldr_req = 1'b0;
        cyc(3);
        #2 rst_n = 1'b1;
        cyc(16);
        check("por_release_2", outs(), 5'b11000);

        // Randomised traffic against the model
        btn_left = 0;
        ej_left = 0;
        for (int c = 0; c < 2500; c++) begin
            if (btn_left == 0) begin
                btn_rst = 1'($urandom_range(1, 0));
                btn_left = ($urandom_range(3, 0) == 0) ? int'($urandom_range(30, 8)) : int'($urandom_range(7, 1));
            end
            btn_left--;
            if (ej_left > 0) begin
                ej_cold_n = 1'b0;
                ej_left--;
            end else begin
                ej_cold_n = 1'b1;
                if ($urandom_range(249, 0) == 0) ej_left = int'($urandom_range(20, 1));
            end
            if ($urandom_range(39, 0) == 0) ldr_req = ~ldr_req;
            ldr_done = ($urandom_range(24, 0) == 0);
            cyc(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
